// File: rtl/ov7670_pixel_capture.sv
// ----------------------------------------------------------------------------
// ov7670_pixel_capture
//
// Pixel-capture stage sitting directly behind the OV7670 camera pins, clocked
// by the camera pixel clock. It samples the byte bus under HREF/VSYNC framing.
// Each pair of consecutive bytes becomes one RGB565 pixel. The pixel leaves
// with a one-cycle valid strobe and its X/Y coordinates. The block also
// produces frame-boundary and error pulses for the frame-buffer writer.
//
// Parameters:
//   H_ACTIVE       active pixels per line (max 1023)
//   V_ACTIVE       active lines per frame (max 511)
//
// Ports:
//   i_PCLK         camera pixel clock, all logic on the rising edge
//   i_Rst          asynchronous active-high reset
//   i_VSYNC        camera VSYNC, high during vertical blanking
//   i_HREF         camera HREF, high while active line bytes are on the bus
//   i_Data[7:0]    camera data bus
//   o_Pixel[15:0]  RGB565 pixel, {first byte, second byte}
//   o_Valid        one-cycle strobe qualifying o_Pixel/o_X/o_Y
//   o_X[9:0]       column of the current pixel
//   o_Y[8:0]       row of the current pixel
//   o_Frame_Start  one-cycle pulse when an active frame begins
//   o_Frame_Done   one-cycle pulse once V_ACTIVE complete lines are captured
//   o_Line_Err     one-cycle pulse on a malformed line (wrong byte count)
//   o_Frame_Err    one-cycle pulse when VSYNC ends a frame early
//
// Build option:
//   OV7670_CAPTURE_DECIMATE_EN  when defined, the block decimates 2x. Only
//                               even columns of even rows are emitted, with
//                               coordinates halved. Error and frame pulses
//                               still use the full-resolution counts.
// ----------------------------------------------------------------------------
module ov7670_pixel_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        i_PCLK,
    input  logic        i_Rst,
    input  logic        i_VSYNC,
    input  logic        i_HREF,
    input  logic [7:0]  i_Data,
    output logic [15:0] o_Pixel,
    output logic        o_Valid,
    output logic [9:0]  o_X,
    output logic [8:0]  o_Y,
    output logic        o_Frame_Start,
    output logic        o_Frame_Done,
    output logic        o_Line_Err,
    output logic        o_Frame_Err
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Registered copies of the pins plus one-cycle-delayed copies for edges
    logic       r_VS;
    logic       r_HREF;
    logic [7:0] r_Data;
    logic       r_VS_d;
    logic       r_HREF_d;

    state_t     state_r;
    state_t     state_s;

    logic [9:0] x_r;
    logic [9:0] x_s;
    logic [8:0] y_r;
    logic [8:0] y_s;
    logic       phase_r;
    logic       phase_s;
    logic [7:0] hi_r;
    logic [7:0] hi_s;
    logic       line_active_r;
    logic       line_active_s;
    logic       overflow_r;
    logic       overflow_s;

    logic        capture_s;
    logic        valid_s;
    logic [15:0] pixel_s;
    logic [9:0]  ox_s;
    logic [8:0]  oy_s;
    logic        fs_s;
    logic        fd_s;
    logic        le_s;
    logic        fe_s;

    logic        vs_rise_s;
    logic        vs_fall_s;
    logic        href_rise_s;
    logic        href_fall_s;

    logic        emit_ok_s;
    logic [9:0]  x_map_s;
    logic [8:0]  y_map_s;

    assign vs_rise_s   = r_VS & ~r_VS_d;
    assign vs_fall_s   = ~r_VS & r_VS_d;
    assign href_rise_s = r_HREF & ~r_HREF_d;
    assign href_fall_s = ~r_HREF & r_HREF_d;

`ifdef OV7670_CAPTURE_DECIMATE_EN
    // Keep only even columns of even rows; coordinates are halved.
    assign emit_ok_s = ~x_r[0] & ~y_r[0];
    assign x_map_s   = {1'b0, x_r[9:1]};
    assign y_map_s   = {1'b0, y_r[8:1]};
`else
    assign emit_ok_s = 1'b1;
    assign x_map_s   = x_r;
    assign y_map_s   = y_r;
`endif

    // Input stage: sample pins once and keep delayed copies for edge detection
    always_ff @(posedge i_PCLK or posedge i_Rst) begin
        if (i_Rst) begin
            r_VS     <= 1'b0;
            r_HREF   <= 1'b0;
            r_Data   <= 8'h00;
            r_VS_d   <= 1'b0;
            r_HREF_d <= 1'b0;
        end else begin
            r_VS     <= i_VSYNC;
            r_HREF   <= i_HREF;
            r_Data   <= i_Data;
            r_VS_d   <= r_VS;
            r_HREF_d <= r_HREF;
        end
    end

    // Frame state register
    always_ff @(posedge i_PCLK or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. SYNC waits for VSYNC high so that a frame already in
    // progress at reset is never captured partially.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_SYNC: begin
                if (r_VS) begin
                    state_s = ST_VBLANK;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_VBLANK: begin
                if (vs_fall_s) begin
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_VBLANK;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise_s) begin
                    state_s = ST_VBLANK;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s = ST_SYNC;
            end
        endcase
    end

    // Output/datapath logic: line byte pairing, counters and pulse generation
    always_comb begin
        x_s           = x_r;
        y_s           = y_r;
        phase_s       = phase_r;
        hi_s          = hi_r;
        line_active_s = line_active_r;
        overflow_s    = overflow_r;
        capture_s     = 1'b0;
        valid_s       = 1'b0;
        pixel_s       = o_Pixel;
        ox_s          = o_X;
        oy_s          = o_Y;
        fs_s          = 1'b0;
        fd_s          = 1'b0;
        le_s          = 1'b0;
        fe_s          = 1'b0;
        case (state_r)
            ST_ACTIVE: begin
                if (vs_rise_s) begin
                    // VSYNC ends the frame. A line still in progress is dropped
                    // without a line error.
                    fe_s          = (y_r < V_LIM);
                    line_active_s = 1'b0;
                    x_s           = 10'd0;
                    phase_s       = 1'b0;
                    overflow_s    = 1'b0;
                end else if (r_HREF) begin
                    // A line is only captured if its HREF rise was seen while
                    // in range. Lines already complete for the frame are ignored.
                    capture_s     = href_rise_s ? (y_r < V_LIM) : line_active_r;
                    line_active_s = capture_s;
                    if (capture_s) begin
                        if (!phase_r) begin
                            hi_s    = r_Data;
                            phase_s = 1'b1;
                        end else begin
                            phase_s = 1'b0;
                            if (x_r < H_LIM) begin
                                x_s = x_r + 10'd1;
                                if (emit_ok_s) begin
                                    valid_s = 1'b1;
                                    pixel_s = {hi_r, r_Data};
                                    ox_s    = x_map_s;
                                    oy_s    = y_map_s;
                                end else begin
                                    valid_s = 1'b0;
                                end
                            end else begin
                                // Extra pixels past the line width are dropped
                                // and the line is marked bad.
                                overflow_s = 1'b1;
                            end
                        end
                    end else begin
                        phase_s = phase_r;
                    end
                end else begin
                    if (href_fall_s && line_active_r) begin
                        le_s = (x_r != H_LIM) || phase_r || overflow_r;
                        y_s  = y_r + 9'd1;
                        fd_s = ((y_r + 9'd1) == V_LIM);
                    end else begin
                        y_s = y_r;
                    end
                    // HREF low: the line state is cleared so that the next
                    // HREF rise starts at phase 0, column 0.
                    line_active_s = 1'b0;
                    x_s           = 10'd0;
                    phase_s       = 1'b0;
                    overflow_s    = 1'b0;
                end
            end
            ST_VBLANK: begin
                if (vs_fall_s) begin
                    fs_s = 1'b1;
                    y_s  = 9'd0;
                end else begin
                    y_s = y_r;
                end
                line_active_s = 1'b0;
                x_s           = 10'd0;
                phase_s       = 1'b0;
                overflow_s    = 1'b0;
            end
            default: begin
                line_active_s = 1'b0;
                x_s           = 10'd0;
                phase_s       = 1'b0;
                overflow_s    = 1'b0;
            end
        endcase
    end

    // Datapath state and registered outputs
    always_ff @(posedge i_PCLK or posedge i_Rst) begin
        if (i_Rst) begin
            x_r           <= 10'd0;
            y_r           <= 9'd0;
            phase_r       <= 1'b0;
            hi_r          <= 8'h00;
            line_active_r <= 1'b0;
            overflow_r    <= 1'b0;
            o_Pixel       <= 16'h0000;
            o_Valid       <= 1'b0;
            o_X           <= 10'd0;
            o_Y           <= 9'd0;
            o_Frame_Start <= 1'b0;
            o_Frame_Done  <= 1'b0;
            o_Line_Err    <= 1'b0;
            o_Frame_Err   <= 1'b0;
        end else begin
            x_r           <= x_s;
            y_r           <= y_s;
            phase_r       <= phase_s;
            hi_r          <= hi_s;
            line_active_r <= line_active_s;
            overflow_r    <= overflow_s;
            o_Pixel       <= pixel_s;
            o_Valid       <= valid_s;
            o_X           <= ox_s;
            o_Y           <= oy_s;
            o_Frame_Start <= fs_s;
            o_Frame_Done  <= fd_s;
            o_Line_Err    <= le_s;
            o_Frame_Err   <= fe_s;
        end
    end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
module tb_ov7670_pixel_capture;

    localparam int H = 8;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [15:0] o_Pixel;
    logic        o_Valid;
    logic [9:0]  o_X;
    logic [8:0]  o_Y;
    logic        o_Frame_Start;
    logic        o_Frame_Done;
    logic        o_Line_Err;
    logic        o_Frame_Err;

    ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .i_PCLK       (clk),
        .i_Rst        (rst),
        .i_VSYNC      (vsync),
        .i_HREF       (href),
        .i_Data       (data),
        .o_Pixel      (o_Pixel),
        .o_Valid      (o_Valid),
        .o_X          (o_X),
        .o_Y          (o_Y),
        .o_Frame_Start(o_Frame_Start),
        .o_Frame_Done (o_Frame_Done),
        .o_Line_Err   (o_Line_Err),
        .o_Frame_Err  (o_Frame_Err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] pix;
        logic [9:0]  x;
        logic [8:0]  y;
        int          c;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int n_fs = 0, n_fd = 0, n_le = 0, n_fe = 0;
    int e_fs = 0, e_fd = 0, e_le = 0, e_fe = 0;
    int fs_cyc = -1;
    int model_y = 0;
    bit in_frame = 1'b0;
    logic [9:0] last_x = 10'd0;
    logic [8:0] last_y = 9'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer and pulse counters
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (o_Valid) begin
                chk("valid_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("pixel", 32'(o_Pixel), 32'(e.pix));
                    chk("x", 32'(o_X), 32'(e.x));
                    chk("y", 32'(o_Y), 32'(e.y));
                    chk("latency", 32'(cyc), 32'(e.c));
                end
            end
            if (o_Frame_Start) begin
                n_fs++;
                fs_cyc = cyc;
            end
            if (o_Frame_Done) n_fd++;
            if (o_Line_Err)   n_le++;
            if (o_Frame_Err)  n_fe++;
        end
    end

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        vsync = vs;
        href  = hr;
        data  = d;
    endtask

    task automatic push_pix(input logic [15:0] p, input int px);
        exp_t e;
`ifdef OV7670_CAPTURE_DECIMATE_EN
        if ((px % 2) == 0 && (model_y % 2) == 0) begin
            e.pix = p; e.x = 10'(px / 2); e.y = 9'(model_y / 2); e.c = cyc + 2;
            sb.push_back(e);
            last_x = e.x; last_y = e.y;
        end
`else
        e.pix = p; e.x = 10'(px); e.y = 9'(model_y); e.c = cyc + 2;
        sb.push_back(e);
        last_x = e.x; last_y = e.y;
`endif
    endtask

    // VSYNC high then low; the fall opens a new frame.
    task automatic vsync_pulse();
        int fs_at;
        if (in_frame && model_y < V) e_fe++;
        in_frame = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        fs_at    = cyc + 2;
        e_fs++;
        model_y  = 0;
        in_frame = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        chk("frame_start_cycle", 32'(fs_cyc), 32'(fs_at));
    endtask

    // Bytes of one line with HREF high; mode 0 = A5/3C pattern, 1 = random.
    task automatic line_bytes(input int nbytes, input bit mode, input bit capture);
        logic [7:0] d;
        logic [7:0] hi;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            if (mode) d = 8'($urandom_range(255, 0));
            else      d = (i % 2 == 1) ? 8'h3C : 8'hA5;
            drive(1'b0, 1'b1, d);
            if (i % 2 == 0) hi = d;
            else if (capture && (i / 2) < H) push_pix({hi, d}, i / 2);
        end
    endtask

    task automatic send_line(input int nbytes, input bit mode);
        bit capture;
        capture = in_frame && (model_y < V);
        line_bytes(nbytes, mode, capture);
        drive(1'b0, 1'b0, 8'h00);
        if (capture) begin
            if (nbytes != 2 * H) e_le++;
            model_y++;
            if (model_y == V) e_fd++;
        end
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_frame_start"}, 32'(n_fs), 32'(e_fs));
        chk({tag, "_frame_done"}, 32'(n_fd), 32'(e_fd));
        chk({tag, "_line_err"}, 32'(n_le), 32'(e_le));
        chk({tag, "_frame_err"}, 32'(n_fe), 32'(e_fe));
        chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outputs"},
            32'({o_Pixel, o_Valid, o_Frame_Start, o_Frame_Done, o_Line_Err, o_Frame_Err}), 32'd0);
        chk({tag, "_xy"}, 32'({o_X, o_Y}), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        // Lines without a preceding VSYNC high are ignored
        send_line(2 * H, 1'b0);
        send_line(2 * H, 1'b1);
        check_counts("no_vsync");

        // Full frame of A5/3C, then one surplus line that must be ignored
        vsync_pulse();
        for (int l = 0; l < V; l++) send_line(2 * H, 1'b0);
        chk("hold_valid", 32'(o_Valid), 32'd0);
        chk("last_x", 32'(o_X), 32'(last_x));
        chk("last_y", 32'(o_Y), 32'(last_y));
        send_line(2 * H + 2, 1'b1);
        check_counts("frame1");

        // Short/long/odd lines, then VSYNC before all lines arrive
        vsync_pulse();
        send_line(2 * H, 1'b1);
        send_line(2 * H, 1'b1);
        send_line(2 * H - 1, 1'b1);
        send_line(2 * H + 4, 1'b1);
        send_line(2 * H, 1'b1);
        vsync_pulse();
        check_counts("short_frame");

        // Next frame captured normally from row 0
        for (int l = 0; l < V; l++) send_line(2 * H, 1'b1);
        check_counts("frame3");

        // VSYNC rises in the middle of a line: line dropped, frame error only
        vsync_pulse();
        send_line(2 * H, 1'b1);
        send_line(2 * H, 1'b1);
        line_bytes(5, 1'b1, 1'b1);
        e_fe++;
        in_frame = 1'b0;
        repeat (2) drive(1'b1, 1'b1, 8'h5A);
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        check_counts("abandon");

        // Reset in the middle of a line
        vsync_pulse();
        send_line(2 * H, 1'b1);
        line_bytes(5, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("mid_reset");
        while (sb.size() > 0 && sb[sb.size() - 1].c > cyc) void'(sb.pop_back());
        in_frame = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        line_bytes(6, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        send_line(2 * H, 1'b1);
        check_counts("after_reset");
        vsync_pulse();
        for (int l = 0; l < V; l++) send_line(2 * H, 1'b1);
        check_counts("resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
